// File: rtl/module_hamming_secded.sv
`default_nettype none
// ============================================================================
//  Module      : module_hamming_secded
//  Description : Hamming SEC-DED encoder/decoder with valid/ready handshake,
//                a single registered output stage and saturating error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module module_hamming_secded #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16,
    // Smallest P with 2^P >= DATA_W+P+1, valid over the 4..32 data range
    localparam int P      = $clog2(DATA_W + 1 + $clog2(DATA_W + 1)),
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CODE_W-1:0] code_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CODE_W-1:0] code_o,
    output logic [DATA_W-1:0] data_o,
    output logic [P-1:0]      syndrome_o,
    output logic              err_corr_o,
    output logic              err_uncorr_o,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  cnt_corr_o,
    output logic [CNT_W-1:0]  cnt_uncorr_o
);

    localparam logic [P-1:0]      c_max_pos = P'(CODE_W - 1);
    localparam logic [CODE_W-1:0] c_one     = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};

    function automatic logic f_is_pow2(input int j);
        return (j & (j - 1)) == 0;
    endfunction

    function automatic int f_log2(input int j);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((j >> i) == 1) r = i;
        end
        return r;
    endfunction

    // Data bit index held at codeword position j (j not a power of two)
    function automatic int f_data_idx(input int j);
        int n;
        n = 0;
        for (int m = 1; m < j; m++) begin
            if (!f_is_pow2(m)) n++;
        end
        return n;
    endfunction

    // Positions 1..CODE_W-1 whose index has bit k set
    function automatic logic [CODE_W-1:0] f_mask(input int k);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int j = 1; j < CODE_W; j++) begin
            if (((j >> k) & 1) != 0) m = m | (c_one << j);
        end
        return m;
    endfunction

    logic [CODE_W-1:1] w_data_vec;
    logic [CODE_W-1:1] w_enc_hi;
    logic [CODE_W-1:0] w_enc;
    logic [P-1:0]      w_par;
    logic [P-1:0]      w_syn;
    logic              w_q;
    logic              w_flip_en;
    logic              w_corr_flag;
    logic              w_uncorr_flag;
    logic [CODE_W-1:0] w_corr;
    logic [DATA_W-1:0] w_dec_data;
    logic              w_in_fire;
    logic              w_out_fire;

    logic              r_valid;
    logic [CODE_W-1:0] r_code;
    logic [DATA_W-1:0] r_data;
    logic [P-1:0]      r_syn;
    logic              r_corr;
    logic              r_uncorr;
    logic [CNT_W-1:0]  r_cnt_corr;
    logic [CNT_W-1:0]  r_cnt_uncorr;

    for (genvar gj = 1; gj < CODE_W; gj++) begin : g_pos
        if (f_is_pow2(gj)) begin : g_parity
            assign w_data_vec[gj] = 1'b0;
            assign w_enc_hi[gj]   = w_par[f_log2(gj)];
        end else begin : g_data
            localparam int c_idx = f_data_idx(gj);
            assign w_data_vec[gj]    = data_i[c_idx];
            assign w_enc_hi[gj]      = data_i[c_idx];
            assign w_dec_data[c_idx] = w_corr[gj];
        end
    end

    for (genvar gk = 0; gk < P; gk++) begin : g_check
        localparam logic [CODE_W-1:0] c_mask = f_mask(gk);
        assign w_par[gk] = ^({w_data_vec, 1'b0} & c_mask);
        assign w_syn[gk] = ^(code_i & c_mask);
    end

    assign w_enc = {w_enc_hi, ^w_enc_hi};
    assign w_q   = ^code_i;

    // A syndrome of zero with Q set points at the overall parity bit itself
    always_comb begin
        w_flip_en     = 1'b0;
        w_corr_flag   = 1'b0;
        w_uncorr_flag = 1'b0;
        if (w_q) begin
            if (w_syn <= c_max_pos) begin
                w_flip_en   = 1'b1;
                w_corr_flag = 1'b1;
            end else begin
                w_uncorr_flag = 1'b1;
            end
        end else if (w_syn != '0) begin
            w_uncorr_flag = 1'b1;
        end
    end

    assign w_corr = w_flip_en ? (code_i ^ (c_one << w_syn)) : code_i;

    assign in_ready_o = !r_valid || out_ready_i;
    assign w_in_fire  = in_valid_i && in_ready_o;
    assign w_out_fire = r_valid && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_code   <= '0;
            r_data   <= '0;
            r_syn    <= '0;
            r_corr   <= 1'b0;
            r_uncorr <= 1'b0;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            if (mode_i) begin
                r_code   <= w_corr;
                r_data   <= w_dec_data;
                r_syn    <= w_syn;
                r_corr   <= w_corr_flag;
                r_uncorr <= w_uncorr_flag;
            end else begin
                r_code   <= w_enc;
                r_data   <= data_i;
                r_syn    <= '0;
                r_corr   <= 1'b0;
                r_uncorr <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    // Events are counted when the result leaves, not when it is accepted
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (w_out_fire) begin
            if (r_corr && (r_cnt_corr != c_cnt_max)) r_cnt_corr <= r_cnt_corr + 1'b1;
            if (r_uncorr && (r_cnt_uncorr != c_cnt_max)) r_cnt_uncorr <= r_cnt_uncorr + 1'b1;
        end
    end

    assign out_valid_o  = r_valid;
    assign code_o       = r_code;
    assign data_o       = r_data;
    assign syndrome_o   = r_syn;
    assign err_corr_o   = r_corr;
    assign err_uncorr_o = r_uncorr;
    assign cnt_corr_o   = r_cnt_corr;
    assign cnt_uncorr_o = r_cnt_uncorr;

endmodule
`default_nettype wire

// File: tb/tb_module_hamming_secded.sv
`default_nettype none
// ============================================================================
//  Module      : tb_module_hamming_secded
//  Description : Scoreboard bench for module_hamming_secded (DATA_W=4, CNT_W=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_module_hamming_secded;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 3;
    localparam int P      = 3;
    localparam int CODE_W = 8;

    typedef struct packed {
        logic [7:0] code;
        logic [3:0] data;
        logic [2:0] syn;
        logic       corr;
        logic       uncorr;
    } res_t;

    typedef struct packed {
        logic       valid;
        logic       ready;
        res_t       res;
        logic [2:0] cc;
        logic [2:0] cu;
    } snap_t;

    logic              clk;
    logic              rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              mode_i;
    logic [DATA_W-1:0] data_i;
    logic [CODE_W-1:0] code_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CODE_W-1:0] code_o;
    logic [DATA_W-1:0] data_o;
    logic [P-1:0]      syndrome_o;
    logic              err_corr_o;
    logic              err_uncorr_o;
    logic              clr_cnt_i;
    logic [CNT_W-1:0]  cnt_corr_o;
    logic [CNT_W-1:0]  cnt_uncorr_o;

    res_t       sb[$];
    logic [2:0] m_cc;
    logic [2:0] m_cu;
    int         n_vec;
    int         n_bad;

    module_hamming_secded #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mode_i      (mode_i),
        .data_i      (data_i),
        .code_i      (code_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .code_o      (code_o),
        .data_o      (data_o),
        .syndrome_o  (syndrome_o),
        .err_corr_o  (err_corr_o),
        .err_uncorr_o(err_uncorr_o),
        .clr_cnt_i   (clr_cnt_i),
        .cnt_corr_o  (cnt_corr_o),
        .cnt_uncorr_o(cnt_uncorr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_pow2(input int j);
        return (j & (j - 1)) == 0;
    endfunction

    // Syndrome as the XOR of the indices of all set bits 1..7
    function automatic logic [2:0] syn_of(input logic [7:0] w);
        logic [2:0] s;
        s = '0;
        for (int j = 1; j < 8; j++) begin
            if (((w >> j) & 8'd1) != 0) s = s ^ 3'(j);
        end
        return s;
    endfunction

    function automatic logic [3:0] extract(input logic [7:0] w);
        logic [3:0] d;
        int idx;
        d = '0;
        idx = 0;
        for (int j = 1; j < 8; j++) begin
            if (!is_pow2(j)) begin
                if (((w >> j) & 8'd1) != 0) d = d | (4'd1 << idx);
                idx++;
            end
        end
        return d;
    endfunction

    function automatic res_t model(input logic m, input logic [3:0] d, input logic [7:0] c);
        res_t r;
        logic [7:0] w;
        logic [2:0] s;
        int idx;
        r = '0;
        if (!m) begin
            w = '0;
            idx = 0;
            for (int j = 1; j < 8; j++) begin
                if (!is_pow2(j)) begin
                    if (((d >> idx) & 4'd1) != 0) w = w | (8'd1 << j);
                    idx++;
                end
            end
            s = syn_of(w);
            for (int k = 0; k < 3; k++) begin
                if (((s >> k) & 3'd1) != 0) w = w | (8'd1 << (1 << k));
            end
            if (^w) w = w | 8'd1;
            r.code = w;
            r.data = d;
        end else begin
            s = syn_of(c);
            w = c;
            // With 8-bit codewords every syndrome names a real position
            if (^c) begin
                w = c ^ (8'd1 << s);
                r.corr = 1'b1;
            end else if (s != 3'd0) begin
                r.uncorr = 1'b1;
            end
            r.code = w;
            r.syn  = s;
            r.data = extract(w);
        end
        return r;
    endfunction

    // One clock of stimulus; returns what the DUT shows now and what the model expects now
    task automatic drive_cycle(input logic v, input logic m, input logic [3:0] d,
                               input logic [7:0] c, input logic ordy, input logic clr,
                               input logic rst, output snap_t obs, output snap_t exp);
        logic ofire;
        logic ifire;
        res_t r;
        in_valid_i  = v;
        mode_i      = m;
        data_i      = d;
        code_i      = c;
        out_ready_i = ordy;
        clr_cnt_i   = clr;
        rst_i       = rst;
        #1;
        obs.valid = out_valid_o;
        obs.ready = in_ready_o;
        obs.res   = {code_o, data_o, syndrome_o, err_corr_o, err_uncorr_o};
        obs.cc    = cnt_corr_o;
        obs.cu    = cnt_uncorr_o;
        exp.valid = (sb.size() != 0);
        exp.ready = !exp.valid || ordy;
        exp.res   = exp.valid ? sb[0] : '0;
        exp.cc    = m_cc;
        exp.cu    = m_cu;
        ofire = exp.valid && ordy;
        ifire = v && exp.ready;
        if (rst) begin
            sb.delete();
            m_cc = '0;
            m_cu = '0;
        end else begin
            r = '0;
            if (ofire) r = sb.pop_front();
            if (clr) begin
                m_cc = '0;
                m_cu = '0;
            end else if (ofire) begin
                if (r.corr && m_cc != 3'd7) m_cc = m_cc + 3'd1;
                if (r.uncorr && m_cu != 3'd7) m_cu = m_cu + 3'd1;
            end
            if (ifire) sb.push_back(model(m, d, c));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        snap_t o, e;
        drive_cycle(1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 1'b1, o, e);
        drive_cycle(1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 1'b1, 1'b1, o, e);
        drive_cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, o, e);
        n_vec++;
        if (o.valid !== 1'b0 || o.ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hs: got valid=%b ready=%b, want valid=0 ready=1", o.valid, o.ready);
        end
        n_vec++;
        if (o.res !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, want 0", o.res);
        end
        n_vec++;
        if (o.cc !== 3'd0 || o.cu !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_counters: got %0d/%0d, want 0/0", o.cc, o.cu);
        end
    endtask

    task automatic test_spec_vectors();
        snap_t o, e;
        logic       tv_mode [5];
        logic [3:0] tv_data [5];
        logic [7:0] tv_code [5];
        res_t       tv_res  [5];
        tv_mode = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tv_data = '{4'hB, 4'h0, 4'h0, 4'h0, 4'h0};
        tv_code = '{8'h00, 8'hAA, 8'h8A, 8'hAB, 8'hCA};
        tv_res  = '{{8'hAA, 4'hB, 3'd0, 1'b0, 1'b0},
                    {8'hAA, 4'hB, 3'd0, 1'b0, 1'b0},
                    {8'hAA, 4'hB, 3'd5, 1'b1, 1'b0},
                    {8'hAA, 4'hB, 3'd0, 1'b1, 1'b0},
                    {8'hCA, 4'hD, 3'd3, 1'b0, 1'b1}};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, tv_mode[i], tv_data[i], tv_code[i], 1'b1, 1'b0, 1'b0, o, e);
            drive_cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, o, e);
            n_vec++;
            if (o.valid !== 1'b1 || o.res !== tv_res[i] || o.res !== e.res ||
                o.cc !== e.cc || o.cu !== e.cu) begin
                n_bad++;
                $display("FAIL spec_vec[%0d]: got v=%b res=%h cnt=%0d/%0d, want v=1 res=%h cnt=%0d/%0d",
                         i, o.valid, o.res, o.cc, o.cu, tv_res[i], e.cc, e.cu);
            end
        end
        drive_cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, o, e);
        n_vec++;
        if (o.cc !== 3'd2 || o.cu !== 3'd1) begin
            n_bad++;
            $display("FAIL spec_counters: got %0d/%0d, want 2/1", o.cc, o.cu);
        end
    endtask

    task automatic test_back_to_back();
        snap_t o, e;
        res_t enc;
        for (int i = 0; i < 34; i++) begin
            if (i < 16) begin
                drive_cycle(1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b0, 1'b0, o, e);
            end else if (i < 32) begin
                enc = model(1'b0, 4'(i), 8'h00);
                drive_cycle(1'b1, 1'b1, 4'h0, enc.code ^ (8'd1 << (i % 8)), 1'b1, 1'b0, 1'b0, o, e);
            end else begin
                drive_cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, o, e);
            end
            n_vec++;
            if (o.valid !== e.valid || o.ready !== e.ready || o.cc !== e.cc || o.cu !== e.cu ||
                (e.valid && o.res !== e.res)) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got v=%b r=%b res=%h cnt=%0d/%0d, want v=%b r=%b res=%h cnt=%0d/%0d",
                         i, o.valid, o.ready, o.res, o.cc, o.cu, e.valid, e.ready, e.res, e.cc, e.cu);
            end
        end
    endtask

    task automatic test_random();
        snap_t o, e;
        res_t enc;
        logic [7:0] c;
        for (int i = 0; i < 80; i++) begin
            enc = model(1'b0, 4'($urandom), 8'h00);
            case ($urandom_range(0, 3))
                0: c = enc.code;
                1: c = enc.code ^ (8'd1 << $urandom_range(0, 7));
                2: c = enc.code ^ (8'd3 << $urandom_range(0, 6));
                default: c = 8'($urandom);
            endcase
            drive_cycle(1'($urandom), 1'($urandom), 4'($urandom), c, ($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 15) == 0), 1'b0, o, e);
            n_vec++;
            if (o.valid !== e.valid || o.ready !== e.ready || o.cc !== e.cc || o.cu !== e.cu ||
                (e.valid && o.res !== e.res)) begin
                n_bad++;
                $display("FAIL random[%0d]: got v=%b r=%b res=%h cnt=%0d/%0d, want v=%b r=%b res=%h cnt=%0d/%0d",
                         i, o.valid, o.ready, o.res, o.cc, o.cu, e.valid, e.ready, e.res, e.cc, e.cu);
            end
        end
    endtask

    task automatic test_stall_reset();
        snap_t o, e;
        drive_cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, o, e);
        drive_cycle(1'b1, 1'b1, 4'h0, 8'hCA, 1'b1, 1'b0, 1'b0, o, e);
        drive_cycle(1'b1, 1'b1, 4'h0, 8'h8A, 1'b1, 1'b0, 1'b0, o, e);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b1, 4'h0, 8'hAA, 1'b0, 1'b0, (i == 3), o, e);
            n_vec++;
            if (o.valid !== 1'b1 || o.ready !== 1'b0 || o.res !== e.res ||
                o.cc !== e.cc || o.cu !== e.cu) begin
                n_bad++;
                $display("FAIL stall[%0d]: got v=%b r=%b res=%h cnt=%0d/%0d, want v=1 r=0 res=%h cnt=%0d/%0d",
                         i, o.valid, o.ready, o.res, o.cc, o.cu, e.res, e.cc, e.cu);
            end
        end
        drive_cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, o, e);
        n_vec++;
        if (o.valid !== 1'b0 || o.ready !== 1'b1 || o.res !== 17'h0 || o.cc !== 3'd0 || o.cu !== 3'd0) begin
            n_bad++;
            $display("FAIL stall_reset: got v=%b r=%b res=%h cnt=%0d/%0d, want v=0 r=1 res=0 cnt=0/0",
                     o.valid, o.ready, o.res, o.cc, o.cu);
        end
    endtask

    task automatic test_clear();
        snap_t o, e;
        drive_cycle(1'b1, 1'b1, 4'h0, 8'h8A, 1'b1, 1'b0, 1'b0, o, e);
        drive_cycle(1'b1, 1'b1, 4'h0, 8'hCA, 1'b1, 1'b0, 1'b0, o, e);
        drive_cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, o, e);
        n_vec++;
        if (o.valid !== 1'b1 || o.res !== e.res || o.cc !== 3'd1 || o.cu !== 3'd0) begin
            n_bad++;
            $display("FAIL clear_pre: got v=%b res=%h cnt=%0d/%0d, want v=1 res=%h cnt=1/0",
                     o.valid, o.res, o.cc, o.cu, e.res);
        end
        drive_cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, o, e);
        n_vec++;
        if (o.valid !== 1'b0 || o.cc !== 3'd0 || o.cu !== 3'd0 || e.cc !== 3'd0 || e.cu !== 3'd0) begin
            n_bad++;
            $display("FAIL clear_post: got v=%b cnt=%0d/%0d, want v=0 cnt=0/0", o.valid, o.cc, o.cu);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        mode_i      = 1'b0;
        data_i      = '0;
        code_i      = '0;
        out_ready_i = 1'b0;
        clr_cnt_i   = 1'b0;
        m_cc        = '0;
        m_cu        = '0;
        n_vec       = 0;
        n_bad       = 0;
        @(negedge clk);
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_random();
        test_stall_reset();
        test_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
